// File: rtl/freq_count_if.sv
// rtl/freq_count_if.sv - control and SRAM port bundle of the frequency-count stage
// slave is the freq_count side; master is the controller/SRAM side.
interface freq_count_if;
  logic       FC_start;
  logic [9:0] src_len;
  logic [7:0] FC_data_R;
  logic       FC_R;
  logic       FC_W;
  logic [9:0] FC_addr;
  logic [7:0] FC_data_W;
  logic       FC_finish;
  logic [8:0] sym_count;

  modport slave (
    input  FC_start, src_len, FC_data_R,
    output FC_R, FC_W, FC_addr, FC_data_W, FC_finish, sym_count
  );

  modport master (
    output FC_start, src_len, FC_data_R,
    input  FC_R, FC_W, FC_addr, FC_data_W, FC_finish, sym_count
  );
endinterface

// File: rtl/freq_count.sv
// rtl/freq_count.sv - byte histogram builder over a shared 8-bit SRAM
// Clears a 256-entry table, then read-modify-writes one saturating count per source byte.
module freq_count #(
  parameter int SRC_BASE  = 0,
  parameter int FREQ_BASE = 768,
  parameter int MAX_LEN   = 512
) (
  input  logic        clk,
  input  logic        rst,
  freq_count_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, RD_SRC, RD_CNT, WR_CNT, DONE} state_t;

  localparam logic [9:0] SRC_A  = 10'(SRC_BASE);
  localparam logic [9:0] FREQ_A = 10'(FREQ_BASE);
  localparam logic [9:0] MAX_A  = 10'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] clr_idx_q, clr_idx_d;
  logic [9:0] idx_q, idx_d;
  logic [9:0] len_q, len_d;
  logic [7:0] sym_q, sym_d;
  logic [8:0] sym_count_q, sym_count_d;
  logic [9:0] idx_inc;

  assign idx_inc = idx_q + 10'd1;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sym_d       = sym_q;
    sym_count_d = sym_count_q;
    case (state_q)
      IDLE: begin
        if (bus.FC_start) begin
          len_d       = (bus.src_len > MAX_A) ? MAX_A : bus.src_len;
          idx_d       = 10'd0;
          sym_count_d = 9'd0;
          clr_idx_d   = 8'd0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + 8'd1;
        if (clr_idx_q == 8'd255) begin
          state_d = (len_q == 10'd0) ? DONE : RD_SRC;
        end
      end
      RD_SRC: state_d = RD_CNT;
      RD_CNT: begin
        sym_d   = bus.FC_data_R;
        state_d = WR_CNT;
      end
      WR_CNT: begin
        // A zero count being bumped means this symbol is seen for the first time.
        if (bus.FC_data_R == 8'd0) begin
          sym_count_d = sym_count_q + 9'd1;
        end
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? DONE : RD_SRC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_idx_q   <= 8'd0;
      idx_q       <= 10'd0;
      len_q       <= 10'd0;
      sym_q       <= 8'd0;
      sym_count_q <= 9'd0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      sym_q       <= sym_d;
      sym_count_q <= sym_count_d;
    end
  end

  // The count address in RD_CNT and the increment in WR_CNT come straight from
  // this cycle's read data, so the memory port is decoded from the state register.
  always_comb begin
    bus.FC_R      = 1'b0;
    bus.FC_W      = 1'b0;
    bus.FC_addr   = 10'd0;
    bus.FC_data_W = 8'd0;
    case (state_q)
      CLEAR: begin
        bus.FC_W    = 1'b1;
        bus.FC_addr = FREQ_A + {2'b00, clr_idx_q};
      end
      RD_SRC: begin
        bus.FC_R    = 1'b1;
        bus.FC_addr = SRC_A + idx_q;
      end
      RD_CNT: begin
        bus.FC_R    = 1'b1;
        bus.FC_addr = FREQ_A + {2'b00, bus.FC_data_R};
      end
      WR_CNT: begin
        bus.FC_W      = 1'b1;
        bus.FC_addr   = FREQ_A + {2'b00, sym_q};
        bus.FC_data_W = (bus.FC_data_R == 8'd255) ? 8'd255 : bus.FC_data_R + 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.FC_finish = (state_q == DONE);
  assign bus.sym_count = sym_count_q;

endmodule

// File: tb/tb_freq_count.sv
// tb/tb_freq_count.sv - directed vector bench for freq_count with an SRAM model
// Vectors carry length, data pattern, finish cycle, symbol count and two table entries.
module tb_freq_count;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_count_if bus();

  freq_count #(.SRC_BASE(0), .FREQ_BASE(768), .MAX_LEN(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [1024];
  logic [7:0] rdata = 8'd0;
  assign bus.FC_data_R = rdata;

  always @(posedge clk) begin
    if (bus.FC_W) mem[bus.FC_addr] <= bus.FC_data_W;
    if (bus.FC_R) rdata <= mem[bus.FC_addr];
  end

  int errors = 0;
  int checks = 0;
  int viol   = 0;
  int fin_cnt = 0;

  always @(negedge clk) begin
    if (bus.FC_R && bus.FC_W) viol++;
    if (!bus.FC_R && !bus.FC_W && (bus.FC_addr != 10'd0 || bus.FC_data_W != 8'd0)) viol++;
    if (bus.FC_finish) fin_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len;
    int kind;
    int ign;
    int exp_cyc;
    int exp_syms;
    int a0;
    int v0;
    int a1;
    int v1;
  } vec_t;

  function automatic logic [7:0] src_byte(input int kind, input int i);
    logic [7:0] abaa [4];
    abaa = '{8'h41, 8'h42, 8'h41, 8'h41};
    case (kind)
      1:       return abaa[i % 4];
      2:       return (i < 300) ? 8'h07 : 8'hFF;
      3:       return 8'(i & 3);
      default: return 8'h00;
    endcase
  endfunction

  task automatic load(input int kind, input int len);
    for (int i = 0; i < 768; i++) mem[i] = 8'h5C;
    for (int i = 0; i < len; i++) mem[i] = src_byte(kind, i);
    for (int s = 0; s < 256; s++) mem[768 + s] = 8'hAA;
  endtask

  function automatic int out_bits();
    return int'({bus.FC_R, bus.FC_W, bus.FC_addr, bus.FC_data_W, bus.FC_finish, bus.sym_count});
  endfunction

  task automatic run(input vec_t v, input string tag);
    int cyc;
    int fin0;
    int eff;
    int mism;
    int expt [256];
    int syms_at_fin;
    load(v.kind, v.len);
    fin0 = fin_cnt;
    @(negedge clk);
    bus.FC_start = 1'b1;
    bus.src_len  = 10'(v.len);
    @(posedge clk); #1;
    bus.FC_start = 1'b0;
    cyc = 1;
    while (!bus.FC_finish && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (v.ign != 0 && cyc == v.ign) begin
        bus.FC_start = 1'b1;
        bus.src_len  = 10'd7;
      end else begin
        bus.FC_start = 1'b0;
      end
    end
    bus.FC_start = 1'b0;
    check({tag, " finish_cycle"}, cyc, v.exp_cyc);
    check({tag, " sym_count"}, int'(bus.sym_count), v.exp_syms);
    syms_at_fin = int'(bus.sym_count);
    check({tag, " entry0"}, int'(mem[v.a0]), v.v0);
    check({tag, " entry1"}, int'(mem[v.a1]), v.v1);
    eff = (v.len > 512) ? 512 : v.len;
    for (int s = 0; s < 256; s++) expt[s] = 0;
    for (int i = 0; i < eff; i++) begin
      if (expt[src_byte(v.kind, i)] < 255) expt[src_byte(v.kind, i)]++;
    end
    mism = 0;
    for (int s = 0; s < 256; s++) if (int'(mem[768 + s]) != expt[s]) mism++;
    check({tag, " table_mismatches"}, mism, 0);
    @(posedge clk); #1;
    check({tag, " finish_one_cycle"}, int'(bus.FC_finish), 0);
    check({tag, " sym_count_stable"}, int'(bus.sym_count), syms_at_fin);
    check({tag, " finish_pulses"}, fin_cnt - fin0, 1);
  endtask

  vec_t vecs [7];

  initial begin
    int bad;
    int cyc;
    vecs[0] = '{len: 0,   kind: 0, ign: 0,   exp_cyc: 257,  exp_syms: 0, a0: 768, v0: 0,   a1: 1023, v1: 0};
    vecs[1] = '{len: 4,   kind: 1, ign: 0,   exp_cyc: 269,  exp_syms: 2, a0: 833, v0: 3,   a1: 834,  v1: 1};
    vecs[2] = '{len: 512, kind: 2, ign: 0,   exp_cyc: 1793, exp_syms: 2, a0: 775, v0: 255, a1: 1023, v1: 212};
    vecs[3] = '{len: 10,  kind: 3, ign: 0,   exp_cyc: 287,  exp_syms: 4, a0: 768, v0: 3,   a1: 771,  v1: 2};
    vecs[4] = '{len: 1,   kind: 4, ign: 0,   exp_cyc: 260,  exp_syms: 1, a0: 768, v0: 1,   a1: 769,  v1: 0};
    vecs[5] = '{len: 600, kind: 2, ign: 0,   exp_cyc: 1793, exp_syms: 2, a0: 775, v0: 255, a1: 1023, v1: 212};
    vecs[6] = '{len: 4,   kind: 1, ign: 100, exp_cyc: 269,  exp_syms: 2, a0: 833, v0: 3,   a1: 834,  v1: 1};

    rst = 1'b1;
    bus.FC_start = 1'b1;
    bus.src_len  = 10'd4;
    load(1, 4);
    @(posedge clk); #1;
    check("reset outputs c1", out_bits(), 0);
    @(posedge clk); #1;
    check("reset outputs c2", out_bits(), 0);
    @(negedge clk);
    bus.FC_start = 1'b0;
    rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_bits() != 0) bad++;
    end
    check("no activity after reset", bad, 0);
    check("no finish after reset", fin_cnt, 0);

    for (int k = 0; k < 7; k++) begin
      run(vecs[k], $sformatf("vec%0d", k));
    end

    load(1, 4);
    @(negedge clk);
    bus.FC_start = 1'b1;
    bus.src_len  = 10'd4;
    @(posedge clk); #1;
    bus.FC_start = 1'b0;
    cyc = 1;
    while (cyc < 262) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst in WR_CNT", int'(bus.FC_W), 1);
    check("midrst sym_count before", int'(bus.sym_count), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst outputs", out_bits(), 0);
    @(negedge clk);
    rst = 1'b0;
    run(vecs[1], "after_midrst");

    check("strobe/idle-bus violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
